ps2_key_event: RTL

Decodes the 16-bit byte-pair word from the PS/2 receiver into discrete key make/break events and buffers them for the CPU. It handles E0/F0 prefixes and holds events in a small show-ahead FIFO. The block sits directly downstream of the PS/2 receiver and upstream of the keyboard MMIO register slot.

---
 rtl/ps2_key_event_if.sv | 50 +++++
 rtl/ps2_key_event.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_if.sv
// ps2_key_event_if: bus between the PS/2 key-event decoder and its consumer.
//
// Handshake: evt_valid is high whenever evt_data holds the oldest buffered
// event (show-ahead). The consumer asserts rd_en for one clock to pop it.
// The pop takes effect on that edge. rd_en while evt_valid is low is ignored.
// fsm_state reports the prefix decoder state for observation only.
interface ps2_key_event_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0] key;
  logic        rd_en;
  logic        clr_ovf;
  logic [9:0]  evt_data;
  logic        evt_valid;
  logic [AW:0] evt_count;
  logic        overflow;
  logic [7:0]  held_code;
  logic        held_ext;
  logic [1:0]  fsm_state;

  // Consumer side: supplies the receiver word and pops events.
  modport master (
    output key,
    output rd_en,
    output clr_ovf,
    input  evt_data,
    input  evt_valid,
    input  evt_count,
    input  overflow,
    input  held_code,
    input  held_ext,
    input  fsm_state
  );

  // Decoder side.
  modport slave (
    input  key,
    input  rd_en,
    input  clr_ovf,
    output evt_data,
    output evt_valid,
    output evt_count,
    output overflow,
    output held_code,
    output held_ext,
    output fsm_state
  );
endinterface

// File: rtl/ps2_key_event.sv
// ps2_key_event: turns the PS/2 receiver byte-pair word into make/break
// events. The word is debounced by a stability counter. Each newly committed
// low byte runs through an E0/F0 prefix decoder. Decoded events
// {ext, brk, code} are buffered in a show-ahead FIFO. The block also tracks
// the most recently pressed key that has not yet been released.
module ps2_key_event #(
  parameter int STABLE_CYCLES = 16,
  parameter int DEPTH         = 8
) (
  input logic           clk,
  input logic           rst_n,
  ps2_key_event_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STABLE_CYCLES);

  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  // Prefix decoder states.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GOT_E0   = 2'd1;
  localparam logic [1:0] ST_GOT_F0   = 2'd2;
  localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  // ---------------------------------------------------------------------
  // Change detection and commit
  // ---------------------------------------------------------------------
  logic [15:0]   cand;
  logic [CW-1:0] cnt;
  logic [15:0]   committed;
  logic          byte_stb;
  logic [7:0]    new_byte;

  // Track the candidate word and count how long it has stayed unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= '0;
      cnt  <= '0;
    end else if (bus.key != cand) begin
      cand <= bus.key;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Commit a stable candidate once. Repeating the same word stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      committed <= '0;
      byte_stb  <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      if ((cnt == CNT_MAX) && (cand != committed)) begin
        committed <= cand;
        byte_stb  <= 1'b1;
      end
    end
  end

  assign new_byte = committed[7:0];

  // ---------------------------------------------------------------------
  // Prefix decoder
  // ---------------------------------------------------------------------
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       emit;
  logic [9:0] evt_new;
  logic       is_discard;

  // Idle/ack/error bytes from the keyboard carry no key information.
  assign is_discard = (new_byte == 8'h00) || (new_byte == 8'hFF) ||
                      (new_byte == 8'hAA) || (new_byte == 8'hFA) ||
                      (new_byte == 8'hFE);

  // Next state and event generation for each committed byte.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    evt_new   = '0;
    if (byte_stb) begin
      if (is_discard) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (new_byte == BYTE_E0) begin
              state_nxt = ST_GOT_E0;
            end else if (new_byte == BYTE_F0) begin
              state_nxt = ST_GOT_F0;
            end else begin
              emit    = 1'b1;
              evt_new = {1'b0, 1'b0, new_byte};
            end
          end
          ST_GOT_E0: begin
            if (new_byte == BYTE_E0) begin
              state_nxt = ST_GOT_E0;
            end else if (new_byte == BYTE_F0) begin
              state_nxt = ST_GOT_E0F0;
            end else begin
              emit      = 1'b1;
              evt_new   = {1'b1, 1'b0, new_byte};
              state_nxt = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            // A second prefix after F0 is a protocol error: resynchronise.
            if ((new_byte != BYTE_E0) && (new_byte != BYTE_F0)) begin
              emit    = 1'b1;
              evt_new = {1'b0, 1'b1, new_byte};
            end
            state_nxt = ST_IDLE;
          end
          default: begin
            if ((new_byte != BYTE_E0) && (new_byte != BYTE_F0)) begin
              emit    = 1'b1;
              evt_new = {1'b1, 1'b1, new_byte};
            end
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Prefix decoder state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  logic          ovf;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign pop   = bus.rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted then.
  assign push  = emit && (!full || pop);
  assign drop  = emit && full && !pop;

  // Storage array; contents are only visible through the gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= evt_new;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: a drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Held-key tracking (follows every decoded event, even dropped ones)
  // ---------------------------------------------------------------------
  logic [7:0] held_code;
  logic       held_ext;

  // A make records the key; only the matching break releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_code <= '0;
      held_ext  <= 1'b0;
    end else if (emit) begin
      if (!evt_new[8]) begin
        held_code <= evt_new[7:0];
        held_ext  <= evt_new[9];
      end else if ((evt_new[7:0] == held_code) && (evt_new[9] == held_ext)) begin
        held_code <= '0;
        held_ext  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.evt_data  = empty ? 10'd0 : mem[rd_ptr];
  assign bus.evt_valid = !empty;
  assign bus.evt_count = count;
  assign bus.overflow  = ovf;
  assign bus.held_code = held_code;
  assign bus.held_ext  = held_ext;
  assign bus.fsm_state = state;

  // Occupancy can never exceed the storage size.
  count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_COUNT);

  // A committed word is reported exactly once.
  stb_single: assert property (@(posedge clk) disable iff (!rst_n)
    byte_stb |=> !byte_stb);

endmodule
